button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 1000000, is the stable-input cycles required to accept a change (10 ms at 100 MHz).
REQ-002 Parameter LONG_CNT, default 200000000, is the debounced-held cycles before a long-press event (2 s at 100 MHz).
REQ-003 Port clk  input  1  is the single system clock; all logic SHALL be rising-edge clocked.
REQ-004 Port rst  input  1  is the reset; it SHALL be synchronous and active-low.
REQ-005 Port button  input  1  is the raw, asynchronous, bouncing push-button, active-high.
REQ-006 Port btn_level  output  1  SHALL be the debounced button level.
REQ-007 Port btn_press  output  1  SHALL be a one-cycle pulse on each accepted press.
REQ-008 Port btn_release  output  1  SHALL be a one-cycle pulse on each accepted release.
REQ-009 Port btn_long  output  1  SHALL be a one-cycle pulse, at most once per press, when the hold reaches LONG_CNT.

Function
REQ-010 button SHALL pass through a 2-flop synchronizer (sync); the FSM SHALL use only the second flop output.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-012 IDLE: sync=1 -> PRESS_WAIT with debounce counter cleared to 0; otherwise stay.
REQ-013 PRESS_WAIT, sync=0: -> IDLE with no output pulse (glitch rejected).
REQ-014 PRESS_WAIT, sync=1, counter=DEBOUNCE_CNT-1: -> HELD; btn_press=1 for the next cycle; btn_level=1; long counter cleared.
REQ-015 PRESS_WAIT, sync=1, counter<DEBOUNCE_CNT-1: counter increments.
REQ-016 HELD, sync=0: -> RELEASE_WAIT with debounce counter cleared.
REQ-017 HELD, sync=1: long counter increments and saturates at LONG_CNT-1.
REQ-018 btn_long SHALL pulse on the single cycle after the long counter first reaches LONG_CNT-1.
REQ-019 RELEASE_WAIT, sync=1: -> HELD; no btn_press; long counter and long-fired flag retained.
REQ-020 RELEASE_WAIT, sync=0, counter=DEBOUNCE_CNT-1: -> IDLE; btn_release=1 for the next cycle; btn_level=0; long-fired flag cleared.
REQ-021 Latency: button high sampled at edge k -> btn_press high in the cycle following edge k+2+DEBOUNCE_CNT; release is symmetric.
REQ-022 All outputs SHALL be registered; btn_press, btn_release and btn_long SHALL never be high in the same cycle.
REQ-023 Counters SHALL be 32 bits wide; DEBOUNCE_CNT and LONG_CNT SHALL each be >=2 and <2^32.

Reset
REQ-024 rst=0 at a clock edge SHALL force IDLE, both counters to 0, the synchronizer flops to 0, the long-fired flag to 0, and all outputs to 0.
REQ-025 Reset asserted mid-press or mid-hold SHALL suppress any pending pulse, including btn_release.
REQ-026 After reset deassertion with button held high, the block SHALL debounce normally and emit btn_press.

Structure
REQ-027 The FSM state encoding (2-bit) and the default DEBOUNCE_CNT/LONG_CNT constants SHALL live in the shared package.
REQ-028 The 2-flop synchronizer SHALL be a sub-module named sync_2ff, instantiated once.

Verification (DEBOUNCE_CNT=4, LONG_CNT=20)
REQ-029 button high from edge 10, held -> btn_press high only in the cycle after edge 16; btn_level=1 from the cycle after edge 16.
REQ-030 3-cycle high glitch while idle -> no pulse on any output; btn_level stays 0.
REQ-031 Held press with 2-cycle low bounces at edges 30 and 40 -> exactly one btn_press, no btn_release.
REQ-032 Hold for 30 cycles after btn_press -> exactly one btn_long, 20 cycles after btn_press; then release -> one btn_release, 7 cycles after button falls.
REQ-033 rst=0 for one cycle while in HELD -> btn_level=0, no btn_release; if button is still high, btn_press re-fires 7 cycles after reset deasserts.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button debouncer: FSM encoding,
// default timing constants and the debug snapshot exported by the top.
package button_debounce_pkg;

  localparam int CNT_W = 32;

  // 10 ms and 2 s at a 100 MHz system clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CNT = 32'd1000000;
  localparam int unsigned DEFAULT_LONG_CNT     = 32'd200000000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  typedef struct packed {
    db_state_e          state;
    logic [CNT_W-1:0]   db_cnt;
    logic [CNT_W-1:0]   long_cnt;
    logic               long_fired;
  } db_debug_t;

endpackage

// File: rtl/button_debounce_if.sv
// Button-side signal bundle: raw button in, debounced level and event pulses out.
// Event pulses are single-cycle strobes with no back-pressure; there is no ready.
interface button_debounce_if;
  logic button;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  modport master (
    output button,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  button,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous button into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: accepts a level change only after DEBOUNCE_CNT stable
// synchronized samples, and reports press / release / long-press as pulses.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT,
  parameter int unsigned LONG_CNT     = DEFAULT_LONG_CNT
) (
  input  logic              clk,
  input  logic              rst,
  button_debounce_if.slave  bif,
  output db_debug_t         dbg
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 32'd1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 32'd1);

  logic sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bif.button),
    .q   (sync)
  );

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
  logic             long_fired_q, long_fired_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    long_cnt_d   = long_cnt_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          press_d    = 1'b1;
          level_d    = 1'b1;
          long_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end else if (long_cnt_q == LONG_LAST) begin
          // Counter parks at its last value; the flag limits the event to once per press.
          if (!long_fired_q) begin
            long_d       = 1'b1;
            long_fired_d = 1'b1;
          end
        end else begin
          long_cnt_d = long_cnt_q + 32'd1;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high resumes the hold without restarting the long-press timer.
        if (sync) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = IDLE;
          release_d    = 1'b1;
          level_d      = 1'b0;
          long_fired_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      long_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      long_cnt_q   <= long_cnt_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
    end
  end

  assign bif.btn_level   = level_q;
  assign bif.btn_press   = press_q;
  assign bif.btn_release = release_q;
  assign bif.btn_long    = long_q;

  assign dbg.state      = state_q;
  assign dbg.db_cnt     = db_cnt_q;
  assign dbg.long_cnt   = long_cnt_q;
  assign dbg.long_fired = long_fired_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CNT=4, LONG_CNT=20: glitch-length table,
// directed timing sequences and a random phase against a run-length reference model.
module tb_button_debounce;
  import button_debounce_pkg::*;

  localparam int DB = 4;
  localparam int LC = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_debounce_if bif ();
  db_debug_t dbg;

  button_debounce #(.DEBOUNCE_CNT(DB), .LONG_CNT(LC)) dut (
    .clk (clk),
    .rst (rst_n),
    .bif (bif),
    .dbg (dbg)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // scoreboard: {level, press, release, long} expected after each edge
  logic [3:0] exp_q[$];

  // reference model: synchronizer pipeline plus run-length of disagreeing samples
  logic m_s1, m_s2, m_level, m_fired;
  int   m_run, m_hold;

  int press_cnt, release_cnt, long_cnt;
  int last_press, last_release, last_long;

  typedef struct {
    int hi_len;
    int exp_press;
    int exp_release;
  } glitch_vec_t;
  glitch_vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    logic s;
    logic p, r, l;
    p = 1'b0; r = 1'b0; l = 1'b0;
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
      m_run = 0; m_hold = 0; m_fired = 1'b0;
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = bif.button;
      if (s != m_level) begin
        // a change is accepted on the (DB+1)-th consecutive disagreeing sample
        m_run++;
        if (m_run == DB + 1) begin
          m_run = 0;
          if (!m_level) begin
            m_level = 1'b1; p = 1'b1; m_hold = 0;
          end else begin
            m_level = 1'b0; r = 1'b1; m_fired = 1'b0;
          end
        end
      end else begin
        if (m_level && m_run == 0) begin
          if (m_hold == LC - 1) begin
            if (!m_fired) begin
              l = 1'b1; m_fired = 1'b1;
            end
          end else begin
            m_hold++;
          end
        end
        m_run = 0;
      end
    end
    exp_q.push_back({m_level, p, r, l});
  endtask

  // driver: one clock edge, model update, then sample away from the edge
  task automatic step();
    logic [3:0] act, e;
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    act = {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long};
    e = exp_q.pop_front();
    check("outputs_vs_model", int'(act), int'(e));
    check("pulse_exclusive", int'($countones(act[2:0]) <= 1), 1);
    if (bif.btn_press)   begin press_cnt++;   last_press = cyc;   end
    if (bif.btn_release) begin release_cnt++; last_release = cyc; end
    if (bif.btn_long)    begin long_cnt++;    last_long = cyc;    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_mon();
    press_cnt = 0; release_cnt = 0; long_cnt = 0;
    last_press = -1; last_release = -1; last_long = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, f, r, len;
    tbl[0] = '{hi_len: 1, exp_press: 0, exp_release: 0};
    tbl[1] = '{hi_len: 3, exp_press: 0, exp_release: 0};
    tbl[2] = '{hi_len: 4, exp_press: 0, exp_release: 0};
    tbl[3] = '{hi_len: 5, exp_press: 1, exp_release: 1};
    tbl[4] = '{hi_len: 6, exp_press: 1, exp_release: 1};
    tbl[5] = '{hi_len: 2, exp_press: 0, exp_release: 0};

    clear_mon();
    bif.button = 1'b1;
    rst_n = 1'b0;
    steps(3);
    check("reset_level", int'(bif.btn_level), 0);
    check("reset_pulses", int'({bif.btn_press, bif.btn_release, bif.btn_long}), 0);
    check("reset_state", int'(dbg.state), int'(IDLE));
    bif.button = 1'b0;
    rst_n = 1'b1;
    steps(4);

    // glitch-length table
    for (int i = 0; i < 6; i++) begin
      steps(10);
      clear_mon();
      bif.button = 1'b1;
      steps(tbl[i].hi_len);
      bif.button = 1'b0;
      steps(14);
      check($sformatf("glitch%0d_press", tbl[i].hi_len), press_cnt, tbl[i].exp_press);
      check($sformatf("glitch%0d_release", tbl[i].hi_len), release_cnt, tbl[i].exp_release);
      check($sformatf("glitch%0d_level", tbl[i].hi_len), int'(bif.btn_level), 0);
    end

    // press latency, long press, release latency
    steps(10);
    clear_mon();
    bif.button = 1'b1;
    b = cyc + 1;
    steps(12);
    check("press_count", press_cnt, 1);
    check("press_latency", last_press, b + 6);
    check("press_level", int'(bif.btn_level), 1);
    steps(30);
    check("long_count", long_cnt, 1);
    check("long_latency", last_long - last_press, 20);
    bif.button = 1'b0;
    f = cyc + 1;
    steps(12);
    check("release_count", release_cnt, 1);
    check("release_latency", last_release, f + 6);
    check("release_level", int'(bif.btn_level), 0);

    // bounces while held
    steps(5);
    clear_mon();
    bif.button = 1'b1;
    steps(10);
    for (int k = 0; k < 2; k++) begin
      bif.button = 1'b0;
      steps(2);
      bif.button = 1'b1;
      steps(8);
    end
    check("bounce_press", press_cnt, 1);
    check("bounce_release", release_cnt, 0);
    check("bounce_level", int'(bif.btn_level), 1);
    bif.button = 1'b0;
    steps(12);
    check("bounce_final_release", release_cnt, 1);

    // one-cycle reset while held
    bif.button = 1'b1;
    steps(12);
    clear_mon();
    rst_n = 1'b0;
    r = cyc + 1;
    step();
    check("rst_held_level", int'(bif.btn_level), 0);
    rst_n = 1'b1;
    steps(12);
    check("rst_held_no_release", release_cnt, 0);
    check("rst_held_repress", press_cnt, 1);
    check("rst_held_repress_latency", last_press, r + 7);
    bif.button = 1'b0;
    steps(12);

    // random bursts checked cycle by cycle against the model
    for (int n = 0; n < 250; n++) begin
      bif.button = ~bif.button;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        rst_n = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
        step();
      end
    end
    rst_n = 1'b1;
    steps(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
